// File: rtl/lsu_bus_pkg.sv
// Shared types and constants for the load/store unit: FSM states, dm_op
// encodings, byte-enable patterns and load-extension helpers.
package lsu_bus_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam logic [2:0] DM_OP_WD = 3'd0;
  localparam logic [2:0] DM_OP_BS = 3'd1;
  localparam logic [2:0] DM_OP_BZ = 3'd2;
  localparam logic [2:0] DM_OP_HS = 3'd3;
  localparam logic [2:0] DM_OP_HZ = 3'd4;
  localparam logic [2:0] DM_OP_SB = 3'd5;
  localparam logic [2:0] DM_OP_SH = 3'd6;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  function automatic lsu_size_e op_size(input logic [2:0] op);
    case (op)
      DM_OP_BS, DM_OP_BZ, DM_OP_SB: op_size = SZ_BYTE;
      DM_OP_HS, DM_OP_HZ, DM_OP_SH: op_size = SZ_HALF;
      default:                      op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    op_signed = (op == DM_OP_BS) || (op == DM_OP_HS);
  endfunction

  function automatic logic [31:0] ext_byte(input logic signed [7:0] b, input logic sgn);
    ext_byte = sgn ? 32'(b) : {24'h0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic signed [15:0] h, input logic sgn);
    ext_half = sgn ? 32'(h) : {16'h0, h};
  endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// External data-bus signals between the load/store unit (master) and the
// memory system (slave): request/grant plus a single response channel.
interface lsu_bus_if #(
  parameter int ADDR_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane steering: byte enables, lane-replicated store data and
// sign/zero-extended load data for a given dm_op and address offset.
module lsu_lane
  import lsu_bus_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sgn;

  assign w_byte = i_data[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];
  assign w_sgn  = op_signed(i_op);

  // Half accesses look only at addr[1] and words at no address bits, so a
  // misaligned access without the exception path rounds down naturally.
  always_comb begin
    o_be    = BE_WORD;
    o_wdata = i_data;
    o_ldata = i_data;
    case (op_size(i_op))
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_data[7:0]}};
        o_ldata = ext_byte(w_byte, w_sgn);
      end
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        o_wdata = {2{i_data[15:0]}};
        o_ldata = ext_half(w_half, w_sgn);
      end
      default: begin
        o_be    = BE_WORD;
        o_wdata = i_data;
        o_ldata = i_data;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit: single-outstanding req/gnt/rvalid bus master that stalls
// the pipeline per access. Define LSU_MISALIGN_EXC_EN to flag misaligned
// half/word accesses instead of issuing them.
module lsu_bus
  import lsu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [2:0]        dm_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              misalign,
  lsu_bus_if.master         bus
);

  lsu_state_e        r_state;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_be;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [2:0]        r_op;
  logic [1:0]        r_addr_lo;

  logic        w_access;
  logic        w_idle;
  logic        w_misalign;
  logic        w_start;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [31:0] w_ld_data;
  logic [31:0] w_st_ldata_unused;
  logic [3:0]  w_ld_be_unused;
  logic [31:0] w_ld_wdata_unused;

  assign w_access = dm_rd | dm_wr;
  assign w_idle   = (r_state == LSU_IDLE);

`ifdef LSU_MISALIGN_EXC_EN
  lsu_size_e w_size;
  assign w_size     = op_size(dm_op);
  assign w_misalign = w_idle & w_access &
                      (((w_size == SZ_HALF) & addr[0]) |
                       ((w_size == SZ_WORD) & (|addr[1:0])));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start  = w_idle & w_access & ~w_misalign;
  // Combinational so the requesting instruction is frozen from its first cycle.
  assign stall    = rst_n & (w_start | (r_state == LSU_REQ) | (r_state == LSU_WAIT));
  assign misalign = rst_n & w_misalign;
  assign rdata    = r_rdata;

  lsu_lane u_lane_st (
    .i_op      (dm_op),
    .i_addr_lo (addr[1:0]),
    .i_data    (wdata),
    .o_be      (w_st_be),
    .o_wdata   (w_st_wdata),
    .o_ldata   (w_st_ldata_unused)
  );

  lsu_lane u_lane_ld (
    .i_op      (r_op),
    .i_addr_lo (r_addr_lo),
    .i_data    (bus.bus_rdata),
    .o_be      (w_ld_be_unused),
    .o_wdata   (w_ld_wdata_unused),
    .o_ldata   (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LSU_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
      r_op        <= DM_OP_WD;
      r_addr_lo   <= 2'b00;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_start) begin
            r_state     <= LSU_REQ;
            r_bus_req   <= 1'b1;
            r_bus_we    <= dm_wr;
            r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_bus_be    <= w_st_be;
            r_bus_wdata <= w_st_wdata;
            r_op        <= dm_op;
            r_addr_lo   <= addr[1:0];
          end
        end
        LSU_REQ: begin
          if (bus.bus_gnt) begin
            r_state   <= LSU_WAIT;
            r_bus_req <= 1'b0;
          end
        end
        LSU_WAIT: begin
          if (bus.bus_rvalid) begin
            r_state <= LSU_DONE;
            r_rdata <= w_ld_data;
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_bus.sv
// Scoreboard bench for lsu_bus: stimulus pushes expected transactions, a
// negedge monitor checks each one when the DONE cycle appears.
module tb_lsu_bus;
  import lsu_bus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        dm_rd;
  logic        dm_wr;
  logic [2:0]  dm_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;

  lsu_bus_if #(.ADDR_W(32)) bus_if ();

  lsu_bus #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dm_rd    (dm_rd),
    .dm_wr    (dm_wr),
    .dm_op    (dm_op),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .misalign (misalign),
    .bus      (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] rd;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives one access and plays the bus slave; dm_* stay high through DONE.
  task automatic access(input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd, input int gdly,
                        input logic [31:0] brd, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wd,
                        input logic [31:0] e_rd, input int e_stalls);
    exp_t e;
    e.we = wr; e.addr = e_addr; e.be = e_be; e.wd = e_wd;
    e.chk_rd = !wr; e.rd = e_rd; e.stalls = e_stalls;
    exp_q.push_back(e);
    @(posedge clk); #1;
    dm_rd = rd; dm_wr = wr; dm_op = op; addr = a; wdata = wd;
    @(posedge clk); #1;
    repeat (gdly) begin @(posedge clk); #1; end
    bus_if.bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_gnt = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = brd;
    @(posedge clk); #1;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'h0;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    dm_rd = 1'b0; dm_wr = 1'b0; dm_op = DM_OP_WD; addr = 32'h0; wdata = 32'h0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin : monitor
    int          scnt;
    logic        seen_req, got_gnt, stable, c_we;
    logic [31:0] c_addr, c_wd;
    logic [3:0]  c_be;
    exp_t        e;
    scnt = 0; seen_req = 1'b0; got_gnt = 1'b0; stable = 1'b1;
    c_we = 1'b0; c_addr = 32'h0; c_wd = 32'h0; c_be = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        scnt = 0; seen_req = 1'b0; got_gnt = 1'b0; stable = 1'b1;
      end else if (stall) begin
        if (scnt == 0) chk("misalign_in_txn", {31'h0, misalign}, 32'h0);
        scnt++;
        if (bus_if.bus_req) begin
          if (!seen_req) begin
            seen_req = 1'b1;
            c_we = bus_if.bus_we; c_addr = bus_if.bus_addr;
            c_be = bus_if.bus_be; c_wd = bus_if.bus_wdata;
          end else if ({c_we, c_addr, c_be, c_wd} !==
                       {bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata}) begin
            stable = 1'b0;
          end
          if (bus_if.bus_gnt) got_gnt = 1'b1;
        end
      end else if (scnt > 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(scnt), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", 32'(scnt), 32'(e.stalls));
          chk("granted",      {31'h0, got_gnt}, 32'h1);
          chk("req_stable",   {31'h0, stable}, 32'h1);
          chk("bus_we",       {31'h0, c_we}, {31'h0, e.we});
          chk("bus_addr",     c_addr, e.addr);
          chk("bus_be",       {28'h0, c_be}, {28'h0, e.be});
          chk("bus_wdata",    c_wd, e.wd);
          if (e.chk_rd) chk("rdata", rdata, e.rd);
        end
        scnt = 0; seen_req = 1'b0; got_gnt = 1'b0; stable = 1'b1;
      end
    end
  end

  initial begin
    rst_n = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; dm_op = DM_OP_WD;
    addr = 32'h0; wdata = 32'h0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
    #12;
    chk("rst_rdata",     rdata, 32'h0);
    chk("rst_bus_req",   {31'h0, bus_if.bus_req}, 32'h0);
    chk("rst_bus_we",    {31'h0, bus_if.bus_we}, 32'h0);
    chk("rst_bus_addr",  bus_if.bus_addr, 32'h0);
    chk("rst_bus_be",    {28'h0, bus_if.bus_be}, 32'h0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst_stall",     {31'h0, stall}, 32'h0);
    chk("rst_misalign",  {31'h0, misalign}, 32'h0);
    #10 rst_n = 1'b1;

    // rd, wr, op, addr, wdata, gnt delay, bus_rdata | exp addr, be, wdata, rdata, stalls
    access(1, 0, DM_OP_WD, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF,
           32'h0000_1004, 4'hF, 32'h0, 32'hDEAD_BEEF, 3);
    access(1, 0, DM_OP_BS, 32'h0000_2003, 32'h0, 0, 32'h80FF_0000,
           32'h0000_2000, 4'b1000, 32'h0, 32'hFFFF_FF80, 3);
    access(1, 0, DM_OP_BZ, 32'h0000_2003, 32'h0, 0, 32'h80FF_0000,
           32'h0000_2000, 4'b1000, 32'h0, 32'h0000_0080, 3);
    access(0, 1, DM_OP_SH, 32'h0000_3002, 32'h0000_ABCD, 4, 32'h0,
           32'h0000_3000, 4'b1100, 32'hABCD_ABCD, 32'h0, 7);
    access(1, 0, DM_OP_HS, 32'h0000_4002, 32'h0, 1, 32'h8001_1234,
           32'h0000_4000, 4'b1100, 32'h0, 32'hFFFF_8001, 4);
    access(1, 0, DM_OP_HZ, 32'h0000_4000, 32'h0, 0, 32'h1234_F00D,
           32'h0000_4000, 4'b0011, 32'h0, 32'h0000_F00D, 3);
    access(0, 1, DM_OP_SB, 32'h0000_5001, 32'h0000_00A5, 2, 32'h0,
           32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 32'h0, 5);
    access(1, 1, DM_OP_WD, 32'h0000_6008, 32'hCAFE_F00D, 0, 32'h0,
           32'h0000_6008, 4'hF, 32'hCAFE_F00D, 32'h0, 3);
    access(1, 0, DM_OP_WD, 32'h0000_7000, 32'h0, 0, 32'h0102_0304,
           32'h0000_7000, 4'hF, 32'h0, 32'h0102_0304, 3);
    access(1, 0, DM_OP_WD, 32'h0000_7004, 32'h0, 0, 32'h0506_0708,
           32'h0000_7004, 4'hF, 32'h0, 32'h0506_0708, 3);

`ifdef LSU_MISALIGN_EXC_EN
    @(posedge clk); #1;
    dm_rd = 1'b1; dm_wr = 1'b0; dm_op = DM_OP_WD; addr = 32'h0000_1002; wdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("mis_flag",    {31'h0, misalign}, 32'h1);
      chk("mis_stall",   {31'h0, stall}, 32'h0);
      chk("mis_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    end
`else
    access(1, 0, DM_OP_WD, 32'h0000_1002, 32'h0, 0, 32'h0BAD_F00D,
           32'h0000_1000, 4'hF, 32'h0, 32'h0BAD_F00D, 3);
`endif
    idle(2);

    // Reset while in REQ: bus_req must drop without waiting for a clock.
    @(posedge clk); #1;
    dm_rd = 1'b1; dm_op = DM_OP_WD; addr = 32'h0000_A000;
    @(posedge clk); #1;
    chk("abort_req_pre", {31'h0, bus_if.bus_req}, 32'h1);
    rst_n = 1'b0; dm_rd = 1'b0;
    #1;
    chk("abort_req_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    chk("abort_req_stall",   {31'h0, stall}, 32'h0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Reset while in WAIT, then a stray response that must be dropped.
    @(posedge clk); #1;
    dm_rd = 1'b1; dm_op = DM_OP_WD; addr = 32'h0000_8000;
    @(posedge clk); #1 bus_if.bus_gnt = 1'b1;
    @(posedge clk); #1 bus_if.bus_gnt = 1'b0;
    chk("abort_wait_pre", {31'h0, stall}, 32'h1);
    rst_n = 1'b0; dm_rd = 1'b0;
    #1;
    chk("abort_wait_stall",   {31'h0, stall}, 32'h0);
    chk("abort_wait_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    chk("abort_wait_rdata",   rdata, 32'h0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h55AA_55AA;
    @(posedge clk); #1;
    bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
    @(negedge clk);
    chk("stray_rvalid_rdata", rdata, 32'h0);
    chk("stray_rvalid_stall", {31'h0, stall}, 32'h0);

    access(1, 0, DM_OP_WD, 32'h0000_9000, 32'h0, 0, 32'h1357_9BDF,
           32'h0000_9000, 4'hF, 32'h0, 32'h1357_9BDF, 3);
    idle(4);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
